// File: rtl/hilo_unit_pkg.sv
// Shared CPU package: Hi/Lo sequencer state encoding and multiply timing defaults.
package hilo_unit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } hilo_state_t;

  // Default number of cycles the external multiplier is kept running.
  localparam int unsigned HILO_MULT_CYCLES = 33;

  // Run counter width; MULT_CYCLES must stay within 1..63.
  localparam int unsigned HILO_CNT_W = 6;
  typedef logic [HILO_CNT_W-1:0] hilo_cnt_t;

endpackage

// File: rtl/hilo_unit.sv
// Hi/Lo register unit: sequences an external multiplier, holds Hi/Lo,
// services mthi/mtlo writes and mfhi/mflo reads with stall on busy.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = HILO_MULT_CYCLES,
  parameter int unsigned WIDTH       = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             MthiEn,
  input  logic             MtloEn,
  input  logic [WIDTH-1:0] WrData,
  input  logic             ReadEn,
  input  logic             ReadSel,
  input  logic [WIDTH-1:0] MultHi,
  input  logic [WIDTH-1:0] MultLo,
  output logic [WIDTH-1:0] MultA,
  output logic [WIDTH-1:0] MultB,
  output logic             MultControl,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic             Conflict,
  output logic [WIDTH-1:0] ReadData
);

  localparam hilo_cnt_t LAST_CNT = hilo_cnt_t'(MULT_CYCLES - 1);

  hilo_state_t      state_q;
  hilo_state_t      state_d;
  hilo_cnt_t        cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic start_go;
  logic run_last;
  logic capture;
  logic wr_hi;
  logic wr_lo;

  // State register, asynchronously forced to IDLE.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode plus status/strobe outputs; requests while busy are dropped.
  always_comb begin
    state_d  = state_q;
    start_go = 1'b0;
    run_last = 1'b0;
    capture  = 1'b0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
    Busy     = 1'b1;
    Done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        Busy     = 1'b0;
        start_go = Start;
        wr_hi    = MthiEn;
        wr_lo    = MtloEn;
        if (Start) state_d = RUN;
      end
      RUN: begin
        run_last = (cnt_q == LAST_CNT);
        if (run_last) state_d = WAIT;
      end
      WAIT: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        capture = 1'b1;
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    Conflict = Busy & (Start | MthiEn | MtloEn);
    Stall    = ReadEn & Busy;
  end

  // Operand latch, run counter and multiplier enable; the counter holds at
  // its last value instead of wrapping, the RUN->WAIT decode stops it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      MultA       <= '0;
      MultB       <= '0;
      cnt_q       <= '0;
      MultControl <= 1'b0;
    end else if (start_go) begin
      MultA       <= OpA;
      MultB       <= OpB;
      cnt_q       <= '0;
      MultControl <= 1'b1;
    end else if (run_last) begin
      MultControl <= 1'b0;
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + hilo_cnt_t'(1);
    end
  end

  // Hi/Lo registers: captured product, or mthi/mtlo writes when idle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (capture) begin
      hi_q <= MultHi;
      lo_q <= MultLo;
    end else begin
      if (wr_hi) hi_q <= WrData;
      if (wr_lo) lo_q <= WrData;
    end
  end

  // Read port selects Hi or Lo directly.
  always_comb begin
    ReadData = ReadSel ? hi_q : lo_q;
  end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 33: cycles MultControl is held high per multiply.
REQ-002 SHALL have parameter WIDTH, default 32: operand and Hi/Lo width.
REQ-003 Clk  in  1  clock; all state changes on rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 Start  in  1  one-cycle multiply request; OpA/OpB are valid in the same cycle.
REQ-006 OpA, OpB  in  32 each  signed multiplicand and multiplier.
REQ-007 MthiEn, MtloEn  in  1 each  write WrData into HiReg or LoReg.
REQ-008 WrData  in  32  data for mthi/mtlo.
REQ-009 ReadEn  in  1  mfhi/mflo request.
REQ-010 ReadSel  in  1  read select: 0 = Lo, 1 = Hi.
REQ-011 MultHi, MultLo  in  32 each  result from the downstream multiplier.
REQ-012 MultA, MultB  out  32 each  operands to the multiplier.
REQ-013 MultControl  out  1  multiplier run enable.
REQ-014 Busy  out  1  high in any state other than IDLE.
REQ-015 Stall  out  1  pipeline stall.
REQ-016 Done  out  1  one-cycle pulse when a result is captured.
REQ-017 Conflict  out  1  one-cycle pulse when a request is ignored.
REQ-018 ReadData  out  32  selected HiReg or LoReg.

Function
REQ-019 FSM states SHALL be IDLE, RUN, WAIT, CAPTURE.
REQ-020 In IDLE, Start SHALL latch OpA->MultA and OpB->MultB, clear the counter, set MultControl, and move to RUN.
REQ-021 In RUN, the counter SHALL increment each cycle; when the counter reaches MULT_CYCLES-1, MultControl SHALL clear and the FSM SHALL move to WAIT.
REQ-022 MultControl SHALL therefore be high for exactly MULT_CYCLES consecutive cycles.
REQ-023 WAIT SHALL last exactly 1 cycle, covering the multiplier's Hi/Lo output register latency, then move to CAPTURE.
REQ-024 CAPTURE SHALL load HiReg<=MultHi and LoReg<=MultLo, pulse Done, and return to IDLE.
REQ-025 Start-to-Done latency SHALL be MULT_CYCLES+2 cycles (35 at default).
REQ-026 MultA and MultB SHALL hold stable from Start until CAPTURE.
REQ-027 Start while Busy SHALL be ignored and SHALL pulse Conflict.
REQ-028 MthiEn/MtloEn while Busy SHALL be ignored and SHALL pulse Conflict.
REQ-029 MthiEn/MtloEn in IDLE SHALL write the register on the next edge; both may be asserted in the same cycle.
REQ-030 If Start and MthiEn/MtloEn occur in the same IDLE cycle, the write SHALL occur and the multiply SHALL start; CAPTURE later overwrites the written value.
REQ-031 ReadData SHALL be combinational from HiReg/LoReg per ReadSel.
REQ-032 Stall SHALL equal ReadEn AND Busy; reads SHALL never return a stale result.
REQ-033 In the CAPTURE cycle, Busy SHALL be high, so a read stalls one cycle and then sees the new value.
REQ-034 Counter SHALL be 6 bits and never wrap; MULT_CYCLES SHALL be in the range 1..63.

Reset
REQ-035 Reset SHALL force state IDLE and clear the counter.
REQ-036 Reset SHALL clear HiReg, LoReg, MultA, MultB, MultControl, Done, Conflict, Stall, and Busy to 0.
REQ-037 Reset mid-RUN SHALL drop MultControl immediately, asynchronously, and SHALL discard the pending result; no Done pulse.

Structure
REQ-038 The FSM state enum and the default MULT_CYCLES constant SHALL live in the shared CPU package.
REQ-039 No sub-module is required; the multiplier is instantiated outside, beside hilo_unit.

Verification
REQ-040 Start with OpA=7, OpB=6, using a behavioural multiplier model -> MultControl high for 33 cycles, Done at cycle 35, HiReg=0, LoReg=42.
REQ-041 Start with OpA=-3 (0xFFFFFFFD), OpB=5 -> HiReg=0xFFFFFFFF, LoReg=0xFFFFFFF1.
REQ-042 Start at cycle 0, second Start at cycle 10 -> Conflict pulses at cycle 10, a single Done, MultA unchanged.
REQ-043 ReadEn=1, ReadSel=1 held during a multiply -> Stall high until IDLE, then ReadData equals the new Hi.
REQ-044 MthiEn with WrData=0xDEADBEEF in IDLE, then ReadSel=1 -> ReadData=0xDEADBEEF; MtloEn while Busy -> Conflict, LoReg unchanged.
REQ-045 Reset asserted at RUN cycle 12 -> MultControl=0 immediately, all outputs 0, no Done; a new Start afterwards completes normally.
